// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types for the synchronous dual-port RAM
package sram_pkg;
  typedef enum logic {S_CLEAR, S_READY} state_e;
  typedef enum logic {RDW_READ_FIRST, RDW_WRITE_FIRST} rdw_mode_e;
endpackage

// File: rtl/sram_clear_seq.sv
// rtl/sram_clear_seq.sv - post-reset clear sweep FSM, counter and busy flag
module sram_clear_seq
  import sram_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             busy_o,
  output logic             clr_we_o,
  output logic [DEPTH-1:0] clr_addr_o
);
  localparam state_e RstState = (CLEAR_ON_RST != 0) ? S_CLEAR : S_READY;

  state_e           state_q, state_d;
  logic [DEPTH:0]   cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RstState;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_o   = 1'b0;
    clr_we_o = 1'b0;
    case (state_q)
      S_CLEAR: begin
        busy_o   = 1'b1;
        clr_we_o = 1'b1;
        cnt_d    = cnt_q + {{DEPTH{1'b0}}, 1'b1};
        // Carry into the extra bit means the last address is being written now.
        if (cnt_d[DEPTH]) state_d = S_READY;
      end
      default: ;
    endcase
  end

  assign clr_addr_o = cnt_q[DEPTH-1:0];
endmodule

// File: rtl/sram_dp.sv
// rtl/sram_dp.sv - synchronous true-dual-port RAM with byte lanes and clear sweep
module sram_dp
  import sram_pkg::*;
#(
  parameter int               DEPTH        = 4,
  parameter int               WIDTH        = 16,
  parameter int               RDW_MODE     = 0,
  parameter int               CLEAR_ON_RST = 1,
  parameter logic [WIDTH-1:0] CLEAR_VAL    = '0
) (
  input  logic                 CLK,
  input  logic                 N_RST,
  input  logic                 A_EN,
  input  logic                 A_WE,
  input  logic [WIDTH/8-1:0]   A_BE,
  input  logic [DEPTH-1:0]     A_ADDR,
  input  logic [WIDTH-1:0]     A_WDATA,
  output logic [WIDTH-1:0]     A_RDATA,
  output logic                 A_VALID,
  input  logic                 B_EN,
  input  logic                 B_WE,
  input  logic [WIDTH/8-1:0]   B_BE,
  input  logic [DEPTH-1:0]     B_ADDR,
  input  logic [WIDTH-1:0]     B_WDATA,
  output logic [WIDTH-1:0]     B_RDATA,
  output logic                 B_VALID,
  output logic                 BUSY,
  output logic                 COLLIDE
);
  localparam int        NB       = WIDTH / 8;
  localparam rdw_mode_e RdwMode  = (RDW_MODE != 0) ? RDW_WRITE_FIRST : RDW_READ_FIRST;
  localparam bit        WrFirst  = (RdwMode == RDW_WRITE_FIRST);

  logic [WIDTH-1:0] mem [2**DEPTH];

  logic             busy, clr_we;
  logic [DEPTH-1:0] clr_addr;

  sram_clear_seq #(.DEPTH(DEPTH), .CLEAR_ON_RST(CLEAR_ON_RST)) u_clear (
    .clk_i      (CLK),
    .rst_ni     (N_RST),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  function automatic logic [WIDTH-1:0] lane_merge(input logic [WIDTH-1:0] old,
                                                  input logic [NB-1:0]    be,
                                                  input logic [WIDTH-1:0] wd);
    logic [WIDTH-1:0] r;
    r = old;
    for (int i = 0; i < NB; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  logic             a_req, b_req, a_wr, b_wr;
  logic             wa_en;
  logic [DEPTH-1:0] wa_addr;
  logic [NB-1:0]    wa_be;
  logic [WIDTH-1:0] wa_data;
  logic [WIDTH-1:0] final_a, final_b;
  logic [WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic             a_valid_q, b_valid_q, collide_q, collide_d;

  assign a_req = A_EN && !busy;
  assign b_req = B_EN && !busy;
  assign a_wr  = a_req && A_WE;
  assign b_wr  = b_req && B_WE;

  // The clear sweep borrows the port A write path; requests are gated off meanwhile.
  assign wa_en   = clr_we || a_wr;
  assign wa_addr = clr_we ? clr_addr  : A_ADDR;
  assign wa_be   = clr_we ? {NB{1'b1}} : A_BE;
  assign wa_data = clr_we ? CLEAR_VAL : A_WDATA;

  // Final word at each port's address: B lanes first, A lanes on top so A wins overlaps.
  always_comb begin
    final_a = mem[wa_addr];
    if (b_wr && (B_ADDR == wa_addr)) final_a = lane_merge(final_a, B_BE, B_WDATA);
    if (wa_en) final_a = lane_merge(final_a, wa_be, wa_data);
    final_b = mem[B_ADDR];
    if (b_wr) final_b = lane_merge(final_b, B_BE, B_WDATA);
    if (wa_en && (wa_addr == B_ADDR)) final_b = lane_merge(final_b, wa_be, wa_data);
  end

  always_ff @(posedge CLK) begin
    if (wa_en) mem[wa_addr] <= final_a;
    if (b_wr)  mem[B_ADDR]  <= final_b;
  end

  always_comb begin
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    if (a_req) a_rdata_d = WrFirst ? final_a : mem[A_ADDR];
    if (b_req) b_rdata_d = WrFirst ? final_b : mem[B_ADDR];
    collide_d = a_wr && b_wr && (A_ADDR == B_ADDR) && |(A_BE & B_BE);
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      collide_q <= 1'b0;
    end else begin
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      a_valid_q <= a_req;
      b_valid_q <= b_req;
      collide_q <= collide_d;
    end
  end

  assign A_RDATA = a_rdata_q;
  assign B_RDATA = b_rdata_q;
  assign A_VALID = a_valid_q;
  assign B_VALID = b_valid_q;
  assign BUSY    = busy;
  assign COLLIDE = collide_q;
endmodule

// File: doc/sram_dp.md
Name: sram_dp

Overview:
Synchronous true-dual-port RAM. It is the clocked, parametrised successor to the asynchronous single-port SRAM model.
- Two independent read/write ports (A, B) with byte-lane write enables.
- Selectable read-during-write mode and deterministic same-address collision handling.
- Optional hardware clear sequence after reset.
- Used as register file / scratch memory behind the CPU and bus bridges, where the async part's N_OE/N_WE contract cannot be met.

Parameters:
DEPTH, 4, address bits; 2**DEPTH words.
WIDTH, 16, data bits; must be a multiple of 8.
RDW_MODE, 0, 0 = read-first (old data returned), 1 = write-first (new merged data returned).
CLEAR_ON_RST, 1, 1 = sweep all words to CLEAR_VAL after reset release; 0 = no sweep, BUSY tied 0.
CLEAR_VAL, 0, WIDTH-bit value written by the clear sweep.

Ports:
CLK  in  1  clock; all state changes on posedge.
N_RST  in  1  asynchronous, active-low reset.
A_EN  in  1  port A request this cycle.
A_WE  in  1  1 = write, 0 = read; valid with A_EN.
A_BE  in  WIDTH/8  byte-lane write enables; bit i covers bits [8i+7:8i].
A_ADDR  in  DEPTH  port A word address.
A_WDATA  in  WIDTH  port A write data.
A_RDATA  out  WIDTH  port A registered read data.
A_VALID  out  1  A_RDATA valid this cycle.
B_EN, B_WE, B_BE, B_ADDR, B_WDATA, B_RDATA, B_VALID: as port A, for port B.
BUSY  out  1  clear sweep in progress; requests ignored.
COLLIDE  out  1  one-cycle pulse: both ports wrote the same address in the same cycle.

Behaviour:
- Reset (N_RST=0, async):
  - A_RDATA=B_RDATA=0, A_VALID=B_VALID=0, COLLIDE=0.
  - BUSY=CLEAR_ON_RST.
  - FSM forced to CLEAR (or READY if CLEAR_ON_RST=0); sweep counter=0.
  - Memory array is not reset asynchronously.
- FSM states:
  - CLEAR: each cycle write CLEAR_VAL (all lanes) to address cnt, then cnt++. After writing address 2**DEPTH-1, go to READY. BUSY drops on the first READY cycle, i.e. 2**DEPTH cycles after reset release.
  - READY: terminal until next reset.
- Reset mid-sweep: sweep restarts from address 0; partial progress discarded.
- Requests while BUSY: ignored entirely. No write, no VALID, no COLLIDE.
- Read (EN=1, WE=0) in READY: RDATA = mem[ADDR] and VALID=1 on the next posedge. Latency is exactly 1.
- RDATA is held when no read is issued; VALID is 0 in that case.
- Write (EN=1, WE=1): only lanes with BE=1 are updated at posedge; other lanes keep their value.
  - A write also returns data: VALID=1 next cycle, RDATA = old word (RDW_MODE=0) or merged new word (RDW_MODE=1).
  - BE=0 write: no update, still VALID=1, RDATA = old word.
- Cross-port read-during-write (one port reads address X while the other writes X): the reader gets data per RDW_MODE, same rule as same-port.
- Both ports write the same address:
  - Per lane, A wins where both BE bits are set. B's lanes apply where only B_BE is set.
  - COLLIDE=1 next cycle only if the BE sets overlap. Both ports return VALID as normal.
  - In write-first mode, both readers see the final merged word.
- Both ports read the same address: no conflict.
- Address width exactly DEPTH; there is no out-of-range case. Counter is DEPTH+1 bits to detect sweep end without wrap ambiguity.

Decomposition:
- sram_pkg: state_e {S_CLEAR, S_READY} and rdw_mode_e {RDW_READ_FIRST, RDW_WRITE_FIRST}. Parameters keep plain int RDW_MODE for instantiation compatibility; RTL compares against the enum.
- Sub-module sram_clear_seq: owns FSM, counter and BUSY. Outputs clear-write enable/address; top muxes these onto the port A write path.
- Lane merge and collision logic stay in sram_dp.

Test Plan:
All cases use DEPTH=4, WIDTH=16 unless stated.
1. Clear sweep: CLEAR_VAL=16'hA5A5; release reset, read all 16 addresses once BUSY=0 -> BUSY high exactly 16 cycles, every read 16'hA5A5 with VALID 1 cycle after EN.
2. Byte-enable merge: write 16'h1234 BE=2'b11 to addr 3, then 16'hFF00 BE=2'b10 -> read addr 3 returns 16'hFF34.
3. Read-during-write, RDW_MODE=0 then 1: addr 5 holds 16'h0001; A writes 16'h0002 to addr 5 while B reads addr 5 -> B_RDATA=16'h0001 (mode 0) / 16'h0002 (mode 1); subsequent read 16'h0002 in both.
4. Collision: A writes 16'hAAAA BE=11 and B writes 16'h5555 BE=01 to addr 7 same cycle -> mem[7]=16'hAAAA, COLLIDE pulses 1 cycle. Repeat with A_BE=10, B_BE=01 -> mem[7]=16'hAA55, COLLIDE stays 0.
5. Reset mid-sweep: assert N_RST low at sweep cycle 9 for 2 cycles, release -> BUSY high a further full 16 cycles, outputs 0 during reset, all words CLEAR_VAL afterwards.
6. Requests during BUSY: issue A write 16'hBEEF to addr 0 on sweep cycle 2 -> no VALID, no COLLIDE, addr 0 reads CLEAR_VAL after sweep; CLEAR_ON_RST=0 variant: BUSY never asserts, first-cycle write succeeds.
